// File: rtl/data_ram_sp.sv
// Single-port data memory for the MEM stage.
// Byte-lane writes, registered reads with RD_LATENCY stages, valid/ready request port,
// in-order response channel with range/alignment errors and an optional post-reset clear.
module data_ram_sp #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned RD_LATENCY     = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [DATA_W/8-1:0]   i_req_sel,
    input  logic [ADDR_W-1:0]     i_req_addr,
    input  logic [DATA_W-1:0]     i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_W-1:0]     o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_init_done
);

    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(BYTES);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned WIDX_W = ADDR_W - OFF_W;

    typedef enum logic [0:0] {StClear, StReady} state_e;

    localparam state_e RstState = CLEAR_ON_RESET ? StClear : StReady;

    state_e              r_state;
    state_e              w_state_next;
    logic [IDX_W-1:0]    r_clr_cnt;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [RD_LATENCY-1:0] r_pv;
    logic [RD_LATENCY-1:0] r_pe;
    logic [DATA_W-1:0]     r_pd [RD_LATENCY];

    logic                w_accept;
    logic [WIDX_W-1:0]   w_word_idx;
    logic [IDX_W-1:0]    w_idx;
    logic                w_err;
    logic                w_wr;
    logic                w_clr_we;
    logic [DATA_W-1:0]   w_mask;
    logic [DATA_W-1:0]   w_rsp_data;
    logic                w_rsp_err;

    assign w_accept   = i_req_valid & o_req_ready;
    assign w_word_idx = i_req_addr[ADDR_W-1:OFF_W];
    assign w_idx      = w_word_idx[IDX_W-1:0];
    // Out-of-range indices are errors, never aliased onto low words.
    assign w_err      = (w_word_idx >= WIDX_W'(DEPTH)) | ~(|i_req_sel)
                      | (|i_req_addr[OFF_W-1:0]);
    assign w_wr       = w_accept & i_req_we & ~w_err;
    // Gate with reset so the clear sequencer never writes while reset is held.
    assign w_clr_we   = i_rst_n & (r_state == StClear);

    // Expand byte-lane selects into a bit mask.
    always_comb begin
        w_mask = '0;
        for (int b = 0; b < int'(BYTES); b++) begin
            w_mask[8*b +: 8] = {8{i_req_sel[b]}};
        end
    end

    // Stage-1 response payload: masked read data, zero for writes and errors.
    always_comb begin
        w_rsp_data = '0;
        if (w_accept & ~i_req_we & ~w_err) begin
            w_rsp_data = r_mem[w_idx] & w_mask;
        end
        w_rsp_err = w_accept & w_err;
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RstState;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: clear walks every word once, then stays ready until reset.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StClear: if (r_clr_cnt == IDX_W'(DEPTH - 1)) w_state_next = StReady;
            StReady: w_state_next = StReady;
            default: w_state_next = RstState;
        endcase
    end

    // FSM outputs.
    always_comb begin
        o_req_ready = (r_state == StReady);
        o_init_done = (r_state == StReady);
    end

    // Clear counter, restarts from word 0 on every reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clr_cnt <= '0;
        end else if (r_state == StClear) begin
            r_clr_cnt <= r_clr_cnt + IDX_W'(1);
        end
    end

    // Storage array (not reset): clear writes or byte-lane request writes.
    always_ff @(posedge i_clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (i_req_sel[b]) begin
                    r_mem[w_idx][8*b +: 8] <= i_req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response pipeline: stage 0 captures at acceptance, later stages add latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pv <= '0;
            r_pe <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_accept;
            r_pe[0] <= w_rsp_err;
            r_pd[0] <= w_rsp_data;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pe[i] <= r_pe[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign o_rsp_valid = r_pv[RD_LATENCY-1];
    assign o_rsp_err   = r_pe[RD_LATENCY-1];
    assign o_rsp_rdata = r_pd[RD_LATENCY-1];

endmodule
